// File: rtl/serial_subtractor_8_bit.sv
// Bit-serial subtractor: d = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// A single full-adder cell computes a + ~b + 1; borrow is the inverted final carry.
module serial_subtractor_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_res, r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_busy, r_done, r_borrow;

  logic w_sum, w_cout;

  assign w_sum  = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_cout = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= ~b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_carry <= w_cout;
          r_res   <= {w_sum, r_res[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_d      <= {w_sum, r_res[WIDTH-1:1]};
            r_borrow <= ~w_cout;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign d      = r_d;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_8_bit.sv
// Directed bench for serial_subtractor_8_bit: vector table plus multi-cycle corner sequences.
module tb_serial_subtractor_8_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow;
  logic [7:0] d;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  serial_subtractor_8_bit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow(borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; walks negedges until done is seen (bounded).
  task automatic wait_done(input logic [7:0] pd, input logic pbr, output int bc,
                           output logic [7:0] rd, output logic rbr, output bit ok,
                           output bit stable);
    bc = 0; ok = 0; stable = 1; rd = '0; rbr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        rd = d; rbr = borrow; ok = 1;
        break;
      end
      if (busy) bc++;
      if (d !== pd || borrow !== pbr) stable = 0;
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
  endtask

  initial begin
    int         bc, t1, t2;
    logic [7:0] rd, pd;
    logic       rbr, pbr;
    bit         ok, st;

    vecs[0] = '{8'd29,  8'd5,   8'd24,  1'b0};
    vecs[1] = '{8'd5,   8'd29,  8'd232, 1'b1};
    vecs[2] = '{8'd0,   8'd1,   8'd255, 1'b1};
    vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vecs[4] = '{8'd200, 8'd95,  8'd105, 1'b0};
    vecs[5] = '{8'd255, 8'd0,   8'd255, 1'b0};
    vecs[6] = '{8'd128, 8'd129, 8'd255, 1'b1};
    vecs[7] = '{8'd0,   8'd0,   8'd0,   1'b0};

    // reset state
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_borrow", borrow, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // vector table
    pd = 8'd0; pbr = 1'b0;
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(pd, pbr, bc, rd, rbr, ok, st);
      check($sformatf("v%0d_timeout", i), ok, 1);
      check($sformatf("v%0d_d", i), rd, vecs[i].d);
      check($sformatf("v%0d_borrow", i), rbr, vecs[i].br);
      check($sformatf("v%0d_busy_cycles", i), bc, 8);
      check($sformatf("v%0d_d_stable", i), st, 1);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), done, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
      check($sformatf("v%0d_d_held", i), d, vecs[i].d);
      pd = vecs[i].d; pbr = vecs[i].br;
    end

    // start during RUN is ignored
    launch(8'd51, 8'd92);          // now at RUN cycle 1
    check("ign_busy_c1", busy, 1);
    repeat (2) @(negedge clk);     // RUN cycle 3
    a = 8'd17; b = 8'd28; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(pd, pbr, bc, rd, rbr, ok, st);
    check("ign_timeout", ok, 1);
    check("ign_d", rd, 215);
    check("ign_borrow", rbr, 1);
    check("ign_busy_rest", bc, 5);
    check("ign_d_stable", st, 1);
    @(negedge clk);
    check("ign_no_restart", busy, 0);
    check("ign_done_1cyc", done, 0);

    // start held high: back-to-back
    @(negedge clk);
    a = 8'd78; b = 8'd255; start = 1'b1;
    @(negedge clk);
    a = 8'd43; b = 8'd59;
    wait_done(8'd215, 1'b1, bc, rd, rbr, ok, st);
    t1 = cyc;
    check("b2b1_timeout", ok, 1);
    check("b2b1_d", rd, 79);
    check("b2b1_borrow", rbr, 1);
    check("b2b1_busy", bc, 8);
    @(negedge clk);
    check("b2b_restart_busy", busy, 1);
    wait_done(8'd79, 1'b1, bc, rd, rbr, ok, st);
    t2 = cyc;
    start = 1'b0;
    check("b2b2_timeout", ok, 1);
    check("b2b2_d", rd, 240);
    check("b2b2_borrow", rbr, 1);
    check("b2b2_d_stable", st, 1);
    check("b2b_spacing", t2 - t1, 9);
    @(negedge clk);
    check("b2b_end_idle", busy, 0);

    // asynchronous reset mid-RUN
    launch(8'd100, 8'd50);         // RUN cycle 1
    repeat (3) @(negedge clk);     // RUN cycle 4
    check("ar_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_d", d, 0);
    check("ar_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 0; bc = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) ok = 1;
      if (busy) bc++;
      @(negedge clk);
    end
    check("ar_no_done", ok, 0);
    check("ar_stay_idle", bc, 0);
    check("ar_d_after", d, 0);
    launch(8'd191, 8'd2);
    wait_done(8'd0, 1'b0, bc, rd, rbr, ok, st);
    check("ar_new_timeout", ok, 1);
    check("ar_new_d", rd, 189);
    check("ar_new_borrow", rbr, 0);
    check("ar_new_busy", bc, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
